// File: rtl/cam_pixel_packer.sv
// Captures one camera frame (two bytes per RGB565 pixel) and writes it to a frame RAM as RGB332.
// All camera inputs are oversampled in the clk domain; pclk is treated as data, never as a clock.
module cam_pixel_packer #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic              pclk,
  input  logic [7:0]        d,
  output logic              px_we,
  output logic [ADDR_W-1:0] px_addr,
  output logic [7:0]        px_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_END  = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_END = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_VS, S_WAIT_FRAME, S_CAPTURE, S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic       vsync_s1_q, vsync_s2_q, vsync_p_q;
  logic       href_s1_q, href_s2_q, href_p_q;
  logic       pclk_s1_q, pclk_s2_q, pclk_p_q;
  logic [7:0] d_s1_q, d_s2_q;

  logic              phase_q, phase_d;
  logic [5:0]        b1_q, b1_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              has_px_q, has_px_d;
  logic              err_q, err_d;
  logic              px_we_q, px_we_d;
  logic [ADDR_W-1:0] px_addr_q, px_addr_d;
  logic [7:0]        px_data_q, px_data_d;

  logic start_ok, vsync_rise, vsync_fall, href_fall, byte_evt;

  // d runs through the same two stages as pclk so a pclk edge event sees the byte it qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_s1_q <= 1'b0; vsync_s2_q <= 1'b0; vsync_p_q <= 1'b0;
      href_s1_q  <= 1'b0; href_s2_q  <= 1'b0; href_p_q  <= 1'b0;
      pclk_s1_q  <= 1'b0; pclk_s2_q  <= 1'b0; pclk_p_q  <= 1'b0;
      d_s1_q     <= '0;   d_s2_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the previous stage's old value.
      vsync_s1_q <= vsync;     vsync_s2_q <= vsync_s1_q; vsync_p_q <= vsync_s2_q;
      href_s1_q  <= href;      href_s2_q  <= href_s1_q;  href_p_q  <= href_s2_q;
      pclk_s1_q  <= pclk;      pclk_s2_q  <= pclk_s1_q;  pclk_p_q  <= pclk_s2_q;
      d_s1_q     <= d;         d_s2_q     <= d_s1_q;
    end
  end

  assign start_ok   = (state_q == S_IDLE) && start;
  assign vsync_rise = vsync_s2_q && !vsync_p_q;
  assign vsync_fall = !vsync_s2_q && vsync_p_q;
  assign href_fall  = !href_s2_q && href_p_q;
  assign byte_evt   = pclk_s2_q && !pclk_p_q && href_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start)      state_d = S_WAIT_VS;
      S_WAIT_VS:    if (vsync_s2_q) state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: if (vsync_fall) state_d = S_CAPTURE;
      S_CAPTURE:    if (vsync_rise) state_d = S_FINISH;
      S_FINISH:                     state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT_VS) || (state_q == S_WAIT_FRAME) || (state_q == S_CAPTURE);
    done = (state_q == S_FINISH);
  end

  // Address tracks line_base + column incrementally; base only advances on lines that produced pixels.
  always_comb begin
    phase_d   = phase_q;
    b1_d      = b1_q;
    col_d     = col_q;
    line_d    = line_q;
    base_d    = base_q;
    addr_d    = addr_q;
    has_px_d  = has_px_q;
    err_d     = err_q;
    px_we_d   = 1'b0;
    px_addr_d = px_addr_q;
    px_data_d = px_data_q;
    if (start_ok) begin
      phase_d  = 1'b0;
      col_d    = '0;
      line_d   = '0;
      base_d   = '0;
      addr_d   = '0;
      has_px_d = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == S_CAPTURE) begin
      if (href_fall) begin
        if (phase_q) err_d = 1'b1;
        phase_d  = 1'b0;
        col_d    = '0;
        has_px_d = 1'b0;
        if (has_px_q && (line_q < LINE_END)) begin
          line_d = line_q + 1'b1;
          if (line_q < LINE_LAST) base_d = base_q + LINE_STEP;
        end
        addr_d = base_d;
      end else if (byte_evt) begin
        if (!phase_q) begin
          b1_d    = {d_s2_q[7:5], d_s2_q[2:0]};
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          has_px_d = 1'b1;
          if ((col_q < COL_END) && (line_q < LINE_END)) begin
            px_we_d   = 1'b1;
            px_addr_d = addr_q;
            px_data_d = {b1_q, d_s2_q[4:3]};
            col_d     = col_q + 1'b1;
            addr_d    = addr_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      if (vsync_rise && (line_d != LINE_END)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= 1'b0;
      b1_q      <= '0;
      col_q     <= '0;
      line_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      has_px_q  <= 1'b0;
      err_q     <= 1'b0;
      px_we_q   <= 1'b0;
      px_addr_q <= '0;
      px_data_q <= '0;
    end else begin
      phase_q   <= phase_d;
      b1_q      <= b1_d;
      col_q     <= col_d;
      line_q    <= line_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      has_px_q  <= has_px_d;
      err_q     <= err_d;
      px_we_q   <= px_we_d;
      px_addr_q <= px_addr_d;
      px_data_q <= px_data_d;
    end
  end

  assign px_we   = px_we_q;
  assign px_addr = px_addr_q;
  assign px_data = px_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer on a reduced 8x6 frame; a monitor logs every RAM write.
module tb_cam_pixel_packer;
  localparam int H = 8;
  localparam int V = 6;
  localparam int AW = 6;
  localparam int NPX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          pclk = 1'b0;
  logic [7:0]    d = 8'h00;
  logic          px_we;
  logic [AW-1:0] px_addr;
  logic [7:0]    px_data;
  logic          busy, done, err;

  cam_pixel_packer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .vsync(vsync), .href(href), .pclk(pclk), .d(d),
    .px_we(px_we), .px_addr(px_addr), .px_data(px_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int            wr_cnt, done_cnt, ovf_cnt;
  bit            first_seen;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [7:0]    mem [NPX];
  int            hits [NPX];
  int            lb [V];

  always @(posedge clk) begin
    #1;
    if (px_we === 1'b1) begin
      wr_cnt++;
      if (!first_seen) first_addr = px_addr;
      first_seen = 1'b1;
      last_addr = px_addr;
      if (int'(px_addr) >= NPX) ovf_cnt++;
      else begin
        hits[px_addr]++;
        mem[px_addr] = px_data;
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; ovf_cnt = 0; first_seen = 1'b0;
    first_addr = '1; last_addr = '0;
    for (int i = 0; i < NPX; i++) begin
      hits[i] = 0;
      mem[i] = 8'h00;
    end
  endtask

  function automatic int unique_addrs();
    int n = 0;
    for (int i = 0; i < NPX; i++) if (hits[i] == 1) n++;
    return n;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    d = b;
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
    pclk = 1'b0;
  endtask

  // Even pixels carry F8/1F (-> E3), odd pixels 07/E0 (-> 1C).
  task automatic send_line(input int nbytes);
    href = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < nbytes; k++) begin
      if (k % 2 == 0) send_byte(((k / 2) % 2 == 0) ? 8'hF8 : 8'h07);
      else            send_byte(((k / 2) % 2 == 0) ? 8'h1F : 8'hE0);
    end
    href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input int nlines);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nlines; i++) send_line(lb[i]);
    vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic std_lines();
    for (int i = 0; i < V; i++) lb[i] = 2 * H;
  endtask

  initial begin
    clear_mon();
    std_lines();
    repeat (3) @(negedge clk);
    check("rst_we", px_we, 0);
    check("rst_addr", px_addr, 0);
    check("rst_data", px_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full frame
    do_start();
    check("start_busy", busy, 1);
    frame(V);
    check("full_writes", wr_cnt, NPX);
    check("full_unique", unique_addrs(), NPX);
    check("full_first", first_addr, 0);
    check("full_last", last_addr, NPX - 1);
    check("full_ovf", ovf_cnt, 0);
    check("full_done", done_cnt, 1);
    check("full_err", err, 0);
    check("full_busy", busy, 0);
    check("pix_e3", mem[0], 8'hE3);
    check("pix_1c", mem[1], 8'h1C);
    check("pix_last", mem[NPX-1], 8'h1C);

    // Start while the camera is mid-frame: nothing until vsync high then low
    clear_mon();
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    do_start();
    send_line(2 * H);
    check("mid_nowrite", wr_cnt, 0);
    check("mid_busy", busy, 1);
    frame(V);
    check("mid_first", first_addr, 0);
    check("mid_writes", wr_cnt, NPX);
    check("mid_err", err, 0);

    // Too many pixels on line 1
    clear_mon();
    lb[1] = 2 * H + 2;
    do_start();
    frame(V);
    check("long_writes", wr_cnt, NPX);
    check("long_unique", unique_addrs(), NPX);
    check("long_line2", mem[2*H], 8'hE3);
    check("long_err", err, 1);
    check("long_done", done_cnt, 1);

    // Odd trailing byte on line 1
    clear_mon();
    std_lines();
    lb[1] = 2 * H + 1;
    do_start();
    check("odd_err_clr", err, 0);
    frame(V);
    check("odd_writes", wr_cnt, NPX);
    check("odd_unique", unique_addrs(), NPX);
    check("odd_err", err, 1);

    // Short frame
    clear_mon();
    std_lines();
    do_start();
    frame(V - 1);
    check("short_done", done_cnt, 1);
    check("short_writes", wr_cnt, (V - 1) * H);
    check("short_err", err, 1);
    do_start();
    check("restart_err", err, 0);
    frame(V);
    check("restart_writes", wr_cnt, (V - 1) * H + NPX);

    // Reset in the middle of line 3
    clear_mon();
    do_start();
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) send_line(2 * H);
    href = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'hF8);
    send_byte(8'h1F);
    send_byte(8'h07);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #2;
    check("mrst_we", px_we, 0);
    check("mrst_addr", px_addr, 0);
    check("mrst_data", px_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    href = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    frame(V);
    check("nostart_writes", wr_cnt, 0);
    check("nostart_done", done_cnt, 0);
    do_start();
    frame(V);
    check("post_first", first_addr, 0);
    check("post_writes", wr_cnt, NPX);
    check("post_unique", unique_addrs(), NPX);
    check("post_done", done_cnt, 1);
    check("post_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
